de_scoreboard_stage: RTL and testbench

- Parametrised successor decode stage for the LC-3b pipeline.
- Replaces fixed per-stage destination-ID comparison with per-register in-flight-writer counters and a condition-code (CC) writer counter, so the pipeline can grow deeper without rewiring the hazard logic.
- Holds the architectural register file and the DE->AGEX pipeline register.
- Supports a squash-decrement port for killed instructions and optional writeback-to-decode forwarding.

---
 rtl/lc3b_pipe_pkg.sv | 51 +++++
 rtl/sb_counter.sv | 58 +++++
 rtl/de_scoreboard_stage.sv | 211 +++++++++++++++++++++
 tb/tb_de_scoreboard_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_pipe_pkg.sv
// Shared LC-3b pipeline definitions: control-store bit positions, widths and
// the decode helper that pulls register IDs and hazard controls out of a
// DE instruction / control-store pair.
package lc3b_pipe_pkg;

  localparam int unsigned IR_W      = 16;
  localparam int unsigned CS_W      = 23;
  localparam int unsigned AGEX_CS_W = 20;
  localparam int unsigned RID_W     = 3;
  localparam int unsigned NUM_REGS  = 8;

  localparam int unsigned CS_SR1_NEEDED = 22;
  localparam int unsigned CS_SR2_NEEDED = 21;
  localparam int unsigned CS_DR_MUX     = 20;
  localparam int unsigned CS_BR_OP      = 10;
  localparam int unsigned CS_BR_STALL   = 7;
  localparam int unsigned CS_LD_REG     = 4;
  localparam int unsigned CS_LD_CC      = 3;

  typedef logic [RID_W-1:0] rid_t;

  // Decoded view of the DE latch used by the scoreboard.
  typedef struct packed {
    rid_t sr1;
    rid_t sr2;
    rid_t dr;
    logic sr1_needed;
    logic sr2_needed;
    logic br_op;
    logic br_stall;
    logic ld_reg;
    logic ld_cc;
  } de_fields_t;

  // SR2 comes from ir[11:9] for store-class opcodes (ir[13] set); DR_MUX forces R7.
  function automatic de_fields_t decode_fields(input logic [IR_W-1:0] ir,
                                               input logic [CS_W-1:0] cs);
    de_fields_t f;
    f.sr1        = ir[8:6];
    f.sr2        = ir[13] ? ir[11:9] : ir[2:0];
    f.dr         = cs[CS_DR_MUX] ? rid_t'(7) : ir[11:9];
    f.sr1_needed = cs[CS_SR1_NEEDED];
    f.sr2_needed = cs[CS_SR2_NEEDED];
    f.br_op      = cs[CS_BR_OP];
    f.br_stall   = cs[CS_BR_STALL];
    f.ld_reg     = cs[CS_LD_REG];
    f.ld_cc      = cs[CS_LD_CC];
    return f;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// In-flight writer counter for one register (or the CC): one increment and
// two independent decrements per cycle, net-applied, clamped to
// [0, MAX_INFLIGHT]. Going below zero means a writeback/squash was reported
// for an instruction that was never counted.
module sb_counter #(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_a_i,
  input  logic             dec_b_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned SUM_W = CNT_W + 2;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SUM_W-1:0] up_c;
  logic [SUM_W-1:0] down_c;
  logic [SUM_W-1:0] net_c;
  logic             underflow_c;

  assign up_c   = SUM_W'(cnt_q) + SUM_W'(inc_i);
  assign down_c = SUM_W'(dec_a_i) + SUM_W'(dec_b_i);
  assign net_c  = up_c - down_c;

  // Net update with clamping at both ends.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_c = 1'b0;
    if (down_c > up_c) begin
      cnt_d       = '0;
      underflow_c = 1'b1;
    end else if (net_c > SUM_W'(MAX_INFLIGHT)) begin
      cnt_d = CNT_W'(MAX_INFLIGHT);
    end else begin
      cnt_d = CNT_W'(net_c);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  // More retirements than issued writers is an upstream bookkeeping bug.
  a_no_underflow : assert property (@(posedge clk) disable iff (reset) !underflow_c);

endmodule

// File: rtl/de_scoreboard_stage.sv
// LC-3b decode stage with counter-based scoreboard.
// Holds the architectural register file, one in-flight-writer counter per
// register plus one for the CC, and the DE->AGEX pipeline latch.
// Optional feature macro: DE_WB_FORWARD_EN -- bypasses writeback data into
// the DE read path so a dependent instruction issues in the writeback cycle.
module de_scoreboard_stage
  import lc3b_pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_v,
  input  logic [IR_W-1:0]      de_ir,
  input  logic [DATA_W-1:0]    de_npc,
  input  logic [CS_W-1:0]      de_cs,
  input  logic                 mem_stall,
  input  logic                 wb_v,
  input  logic                 wb_ld_reg,
  input  logic                 wb_ld_cc,
  input  logic [RID_W-1:0]     wb_drid,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 sq_v,
  input  logic                 sq_ld_reg,
  input  logic                 sq_ld_cc,
  input  logic [RID_W-1:0]     sq_drid,
  output logic                 dep_stall,
  output logic                 v_de_br_stall,
  output logic                 de_issue,
  output logic                 agex_v,
  output logic [DATA_W-1:0]    agex_npc,
  output logic [DATA_W-1:0]    agex_sr1,
  output logic [DATA_W-1:0]    agex_sr2,
  output logic [RID_W-1:0]     agex_drid,
  output logic [AGEX_CS_W-1:0] agex_cs,
  output logic                 sb_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  de_fields_t          de_f_c;
  logic [CNT_W-1:0]    reg_cnt [NUM_REGS];
  logic [CNT_W-1:0]    cc_cnt;
  logic [DATA_W-1:0]   rf_q    [NUM_REGS];

  logic [NUM_REGS-1:0] reg_inc_c;
  logic [NUM_REGS-1:0] wb_dec_c;
  logic [NUM_REGS-1:0] sq_dec_c;
  logic [NUM_REGS-1:0] reg_nz_c;
  logic                cc_inc_c;
  logic                cc_wb_dec_c;
  logic                cc_sq_dec_c;

  logic                fwd_sr1_c;
  logic                fwd_sr2_c;
  logic                fwd_cc_c;
  logic                sr1_haz_c;
  logic                sr2_haz_c;
  logic                br_haz_c;
  logic                sat_haz_c;
  logic                dep_stall_c;
  logic                de_issue_c;
  logic [DATA_W-1:0]   sr1_data_c;
  logic [DATA_W-1:0]   sr2_data_c;

  logic                agex_v_q,    agex_v_d;
  logic [DATA_W-1:0]   agex_npc_q,  agex_npc_d;
  logic [DATA_W-1:0]   agex_sr1_q,  agex_sr1_d;
  logic [DATA_W-1:0]   agex_sr2_q,  agex_sr2_d;
  logic [RID_W-1:0]    agex_drid_q, agex_drid_d;
  logic [AGEX_CS_W-1:0] agex_cs_q,  agex_cs_d;

  assign de_f_c = decode_fields(de_ir, de_cs);

`ifdef DE_WB_FORWARD_EN
  // A sole in-flight writer retiring this cycle (and not being squashed) can be bypassed.
  function automatic logic reg_fwd_ok(input rid_t r);
    return wb_v & wb_ld_reg & (wb_drid == r) & (reg_cnt[r] == CNT_W'(1)) &
           ~(sq_v & sq_ld_reg & (sq_drid == r));
  endfunction
`endif

  // Bypass qualification for SR1, SR2 and the CC.
  always_comb begin
    fwd_sr1_c = 1'b0;
    fwd_sr2_c = 1'b0;
    fwd_cc_c  = 1'b0;
`ifdef DE_WB_FORWARD_EN
    fwd_sr1_c = reg_fwd_ok(de_f_c.sr1);
    fwd_sr2_c = reg_fwd_ok(de_f_c.sr2);
    fwd_cc_c  = wb_v & wb_ld_cc & (cc_cnt == CNT_W'(1)) & ~(sq_v & sq_ld_cc);
`endif
  end

  // Hazard detection and issue decision.
  always_comb begin
    sr1_haz_c   = de_f_c.sr1_needed & (reg_cnt[de_f_c.sr1] != '0) & ~fwd_sr1_c;
    sr2_haz_c   = de_f_c.sr2_needed & (reg_cnt[de_f_c.sr2] != '0) & ~fwd_sr2_c;
    br_haz_c    = de_f_c.br_op & (cc_cnt != '0) & ~fwd_cc_c;
    sat_haz_c   = (de_f_c.ld_reg & (reg_cnt[de_f_c.dr] == CNT_W'(MAX_INFLIGHT))) |
                  (de_f_c.ld_cc  & (cc_cnt == CNT_W'(MAX_INFLIGHT)));
    dep_stall_c = de_v & (sr1_haz_c | sr2_haz_c | br_haz_c | sat_haz_c);
    de_issue_c  = de_v & ~dep_stall_c & ~mem_stall;
  end

  // Source operand read with optional writeback bypass.
  always_comb begin
    sr1_data_c = fwd_sr1_c ? wb_data : rf_q[de_f_c.sr1];
    sr2_data_c = fwd_sr2_c ? wb_data : rf_q[de_f_c.sr2];
  end

  // One-hot increment/decrement strobes for the counter bank.
  always_comb begin
    reg_inc_c               = '0;
    wb_dec_c                = '0;
    sq_dec_c                = '0;
    reg_inc_c[de_f_c.dr]    = de_issue_c & de_f_c.ld_reg;
    wb_dec_c[wb_drid]       = wb_v & wb_ld_reg;
    sq_dec_c[sq_drid]       = sq_v & sq_ld_reg;
    cc_inc_c                = de_issue_c & de_f_c.ld_cc;
    cc_wb_dec_c             = wb_v & wb_ld_cc;
    cc_sq_dec_c             = sq_v & sq_ld_cc;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    sb_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
    ) u_reg_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (reg_inc_c[i]),
      .dec_a_i (wb_dec_c[i]),
      .dec_b_i (sq_dec_c[i]),
      .cnt_o   (reg_cnt[i])
    );

    assign reg_nz_c[i] = (reg_cnt[i] != '0);

    // Architectural register entry, written at writeback.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rf_q[i] <= '0;
      end else if (wb_dec_c[i]) begin
        rf_q[i] <= wb_data;
      end
    end
  end

  sb_counter #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_cc_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (cc_inc_c),
    .dec_a_i (cc_wb_dec_c),
    .dec_b_i (cc_sq_dec_c),
    .cnt_o   (cc_cnt)
  );

  // AGEX latch next state: loads on every non-stalled cycle, holds under mem_stall.
  always_comb begin
    agex_v_d    = agex_v_q;
    agex_npc_d  = agex_npc_q;
    agex_sr1_d  = agex_sr1_q;
    agex_sr2_d  = agex_sr2_q;
    agex_drid_d = agex_drid_q;
    agex_cs_d   = agex_cs_q;
    if (!mem_stall) begin
      agex_v_d    = de_v & ~dep_stall_c;
      agex_npc_d  = de_npc;
      agex_sr1_d  = sr1_data_c;
      agex_sr2_d  = sr2_data_c;
      agex_drid_d = de_f_c.dr;
      agex_cs_d   = de_cs[AGEX_CS_W-1:0];
    end
  end

  // AGEX latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      agex_v_q    <= 1'b0;
      agex_npc_q  <= '0;
      agex_sr1_q  <= '0;
      agex_sr2_q  <= '0;
      agex_drid_q <= '0;
      agex_cs_q   <= '0;
    end else begin
      agex_v_q    <= agex_v_d;
      agex_npc_q  <= agex_npc_d;
      agex_sr1_q  <= agex_sr1_d;
      agex_sr2_q  <= agex_sr2_d;
      agex_drid_q <= agex_drid_d;
      agex_cs_q   <= agex_cs_d;
    end
  end

  assign dep_stall     = dep_stall_c;
  assign de_issue      = de_issue_c;
  assign v_de_br_stall = de_v & de_f_c.br_stall;
  assign sb_busy       = (|reg_nz_c) | (cc_cnt != '0);
  assign agex_v        = agex_v_q;
  assign agex_npc      = agex_npc_q;
  assign agex_sr1      = agex_sr1_q;
  assign agex_sr2      = agex_sr2_q;
  assign agex_drid     = agex_drid_q;
  assign agex_cs       = agex_cs_q;

endmodule

// File: tb/tb_de_scoreboard_stage.sv
// Directed bench for de_scoreboard_stage with an abstract model of the
// scoreboard (integer writer counts, register array, latch image).
module tb_de_scoreboard_stage;

`ifdef DE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int MAXF = 3;

  localparam logic [22:0] SR1N  = 23'h400000;
  localparam logic [22:0] SR2N  = 23'h200000;
  localparam logic [22:0] DRMUX = 23'h100000;
  localparam logic [22:0] LDREG = 23'h000010;
  localparam logic [22:0] LDCC  = 23'h000008;
  localparam logic [22:0] BRCS  = 23'h008481;  // BR_OP | BR_STALL | bits 15,0
  localparam logic [15:0] BRIR  = 16'h0E02;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_v;
  logic [15:0] de_ir;
  logic [15:0] de_npc;
  logic [22:0] de_cs;
  logic        mem_stall;
  logic        wb_v, wb_ld_reg, wb_ld_cc;
  logic [2:0]  wb_drid;
  logic [15:0] wb_data;
  logic        sq_v, sq_ld_reg, sq_ld_cc;
  logic [2:0]  sq_drid;
  logic        dep_stall, v_de_br_stall, de_issue, agex_v, sb_busy;
  logic [15:0] agex_npc, agex_sr1, agex_sr2;
  logic [2:0]  agex_drid;
  logic [19:0] agex_cs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  de_scoreboard_stage #(.DATA_W(16), .MAX_INFLIGHT(3)) dut (
    .clk(clk), .reset(reset), .de_v(de_v), .de_ir(de_ir), .de_npc(de_npc),
    .de_cs(de_cs), .mem_stall(mem_stall), .wb_v(wb_v), .wb_ld_reg(wb_ld_reg),
    .wb_ld_cc(wb_ld_cc), .wb_drid(wb_drid), .wb_data(wb_data), .sq_v(sq_v),
    .sq_ld_reg(sq_ld_reg), .sq_ld_cc(sq_ld_cc), .sq_drid(sq_drid),
    .dep_stall(dep_stall), .v_de_br_stall(v_de_br_stall), .de_issue(de_issue),
    .agex_v(agex_v), .agex_npc(agex_npc), .agex_sr1(agex_sr1), .agex_sr2(agex_sr2),
    .agex_drid(agex_drid), .agex_cs(agex_cs), .sb_busy(sb_busy)
  );

  // Model state.
  int          m_cnt [8];
  int          m_cc;
  logic [15:0] m_rf  [8];
  logic        m_v;
  logic [15:0] m_npc, m_sr1, m_sr2;
  logic [2:0]  m_drid;
  logic [19:0] m_cs;

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic        brst;
    logic        busy;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  dr;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit fwd_reg(input int r);
    return FWD && wb_v && wb_ld_reg && int'(wb_drid) == r && m_cnt[r] == 1 &&
           !(sq_v && sq_ld_reg && int'(sq_drid) == r);
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int   s1, s2, d;
    bit   f1, f2, fc, h;
    s1 = int'(de_ir[8:6]);
    s2 = de_ir[13] ? int'(de_ir[11:9]) : int'(de_ir[2:0]);
    d  = de_cs[20] ? 7 : int'(de_ir[11:9]);
    f1 = fwd_reg(s1);
    f2 = fwd_reg(s2);
    fc = FWD && wb_v && wb_ld_cc && m_cc == 1 && !(sq_v && sq_ld_cc);
    h  = (de_cs[22] && m_cnt[s1] != 0 && !f1) ||
         (de_cs[21] && m_cnt[s2] != 0 && !f2) ||
         (de_cs[10] && m_cc != 0 && !fc) ||
         (de_cs[4] && m_cnt[d] >= MAXF) ||
         (de_cs[3] && m_cc >= MAXF);
    e.stall = de_v && h;
    e.issue = de_v && !h && !mem_stall;
    e.brst  = de_v && de_cs[7];
    e.busy  = (m_cc != 0);
    for (int i = 0; i < 8; i++) if (m_cnt[i] != 0) e.busy = 1'b1;
    e.d1 = f1 ? wb_data : m_rf[s1];
    e.d2 = f2 ? wb_data : m_rf[s2];
    e.dr = 3'(d);
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_rf[i]  = '0;
    end
    m_cc = 0; m_v = 1'b0; m_npc = '0; m_sr1 = '0; m_sr2 = '0; m_drid = '0; m_cs = '0;
  endtask

  task automatic model_update();
    exp_t e;
    int   n;
    if (reset) begin
      model_clear();
      return;
    end
    e = expect_now();
    for (int r = 0; r < 8; r++) begin
      n = m_cnt[r];
      if (e.issue && de_cs[4] && int'(e.dr) == r) n++;
      if (wb_v && wb_ld_reg && int'(wb_drid) == r) n--;
      if (sq_v && sq_ld_reg && int'(sq_drid) == r) n--;
      m_cnt[r] = (n < 0) ? 0 : n;
    end
    n = m_cc + ((e.issue && de_cs[3]) ? 1 : 0) - ((wb_v && wb_ld_cc) ? 1 : 0)
             - ((sq_v && sq_ld_cc) ? 1 : 0);
    m_cc = (n < 0) ? 0 : n;
    if (wb_v && wb_ld_reg) m_rf[wb_drid] = wb_data;
    if (!mem_stall) begin
      m_v    = de_v && !e.stall;
      m_npc  = de_npc;
      m_sr1  = e.d1;
      m_sr2  = e.d2;
      m_drid = e.dr;
      m_cs   = de_cs[19:0];
    end
  endtask

  task automatic compare_all();
    exp_t e;
    e = expect_now();
    chk("dep_stall",     32'(dep_stall),     32'(e.stall));
    chk("v_de_br_stall", 32'(v_de_br_stall), 32'(e.brst));
    chk("de_issue",      32'(de_issue),      32'(e.issue));
    chk("sb_busy",       32'(sb_busy),       32'(e.busy));
    chk("agex_v",        32'(agex_v),        32'(m_v));
    chk("agex_npc",      32'(agex_npc),      32'(m_npc));
    chk("agex_sr1",      32'(agex_sr1),      32'(m_sr1));
    chk("agex_sr2",      32'(agex_sr2),      32'(m_sr2));
    chk("agex_drid",     32'(agex_drid),     32'(m_drid));
    chk("agex_cs",       32'(agex_cs),       32'(m_cs));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [15:0] mk_add(input int d, input int s1, input int s2);
    return {4'b0001, 3'(d), 3'(s1), 3'b000, 3'(s2)};
  endfunction

  task automatic wb_set(input logic v, input logic lr, input logic lc,
                        input logic [2:0] id, input logic [15:0] dat);
    wb_v = v; wb_ld_reg = lr; wb_ld_cc = lc; wb_drid = id; wb_data = dat;
  endtask

  // Retire every outstanding writer via writeback, bounded.
  task automatic drain();
    int r;
    de_v = 1'b0;
    for (int k = 0; k < 40; k++) begin
      r = -1;
      for (int i = 0; i < 8; i++) if (m_cnt[i] > 0 && r < 0) r = i;
      if (r < 0 && m_cc == 0) break;
      wb_set(1'b1, r >= 0, m_cc > 0, (r >= 0) ? 3'(r) : 3'd0, 16'h00A0 + 16'(k));
      tick();
    end
    wb_set(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1 chk("drain_idle", 32'(sb_busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; de_v = 1'b0; de_ir = '0; de_npc = '0; de_cs = '0; mem_stall = 1'b0;
    wb_set(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    sq_v = 1'b0; sq_ld_reg = 1'b0; sq_ld_cc = 1'b0; sq_drid = '0;
    model_clear();
    #1;
    chk("rst_agex_v", 32'(agex_v), 0);
    chk("rst_busy", 32'(sb_busy), 0);
    tick(); tick();
    reset = 1'b0;

    // RAW on R1 resolved by writeback of 0x1234.
    de_v = 1'b1; de_ir = mk_add(1, 0, 0); de_cs = SR1N | SR2N | LDREG | LDCC; de_npc = 16'h3002;
    #1 chk("s1_issue", 32'(de_issue), 1);
    tick();
    chk("s1_agex_drid", 32'(agex_drid), 1);
    chk("s1_agex_npc", 32'(agex_npc), 32'h3002);
    chk("s1_busy", 32'(sb_busy), 1);
    de_ir = mk_add(2, 1, 0); de_cs = SR1N | LDREG; de_npc = 16'h3004;
    #1 chk("s1_raw_stall", 32'(dep_stall), 1);
    tick();
    chk("s1_bubble", 32'(agex_v), 0);
    wb_set(1'b1, 1'b1, 1'b1, 3'd1, 16'h1234);
    #1 chk("s1_wb_cycle_stall", 32'(dep_stall), FWD ? 0 : 1);
    tick();
    chk("s1_wb_cycle_agex_v", 32'(agex_v), FWD ? 1 : 0);
    wb_set(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1 chk("s1_post_wb_stall", 32'(dep_stall), 0);
    tick();
    chk("s1_agex_sr1", 32'(agex_sr1), 32'h1234);
    chk("s1_agex_v", 32'(agex_v), 1);
    drain();

    // Three writers to R2 saturate; the fourth waits for a writeback.
    de_v = 1'b1; de_ir = mk_add(2, 0, 0); de_cs = LDREG; de_npc = 16'h3010;
    repeat (3) tick();
    #1 chk("s2_sat_stall", 32'(dep_stall), 1);
    chk("s2_sat_issue", 32'(de_issue), 0);
    tick();
    wb_set(1'b1, 1'b1, 1'b0, 3'd2, 16'h5555);
    #1 chk("s2_sat_with_wb", 32'(dep_stall), 1);
    tick();
    wb_set(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1 chk("s2_after_wb_issue", 32'(de_issue), 1);
    tick();
    chk("s2_agex_v", 32'(agex_v), 1);
    drain();

    // Branch waits on CC writer: cleared by writeback, then by squash.
    de_v = 1'b1; de_ir = mk_add(3, 0, 0); de_cs = LDREG | LDCC;
    tick();
    de_ir = BRIR; de_cs = BRCS;
    #1 chk("s3_br_stall", 32'(dep_stall), 1);
    chk("s3_br_stall_out", 32'(v_de_br_stall), 1);
    tick();
    wb_set(1'b1, 1'b0, 1'b1, 3'd3, 16'h0);
    #1 chk("s3_br_wb_cycle", 32'(dep_stall), FWD ? 0 : 1);
    tick();
    wb_set(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1 chk("s3_br_issue", 32'(de_issue), 1);
    tick();
    chk("s3_agex_cs", 32'(agex_cs), 32'h08481);
    de_ir = mk_add(4, 0, 0); de_cs = LDCC;
    tick();
    de_ir = BRIR; de_cs = BRCS;
    #1 chk("s3_br_stall2", 32'(dep_stall), 1);
    tick();
    sq_v = 1'b1; sq_ld_reg = 1'b0; sq_ld_cc = 1'b1; sq_drid = 3'd4;
    #1 chk("s3_sq_cycle_stall", 32'(dep_stall), 1);
    tick();
    sq_v = 1'b0; sq_ld_cc = 1'b0;
    #1 chk("s3_sq_cleared", 32'(dep_stall), 0);
    tick();
    drain();

    // mem_stall freezes the latch; writeback still retires R4.
    de_v = 1'b1; de_ir = mk_add(4, 0, 0); de_cs = LDREG; de_npc = 16'h3040;
    tick();
    de_ir = mk_add(5, 0, 0); de_npc = 16'h3042; mem_stall = 1'b1;
    #1 chk("s4_ms_issue", 32'(de_issue), 0);
    tick();
    wb_set(1'b1, 1'b1, 1'b0, 3'd4, 16'hBEEF);
    tick();
    wb_set(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    tick();
    chk("s4_hold_drid", 32'(agex_drid), 4);
    chk("s4_hold_npc", 32'(agex_npc), 32'h3040);
    chk("s4_hold_v", 32'(agex_v), 1);
    mem_stall = 1'b0;
    #1 chk("s4_release_issue", 32'(de_issue), 1);
    chk("s4_wb_during_stall", 32'(sb_busy), 0);
    tick();
    chk("s4_release_drid", 32'(agex_drid), 5);
    drain();

    // Issue plus writeback to R3 in one cycle leaves one writer outstanding.
    de_v = 1'b1; de_ir = mk_add(3, 0, 0); de_cs = LDREG;
    tick();
    wb_set(1'b1, 1'b1, 1'b0, 3'd3, 16'h0333);
    #1 chk("s5_issue_with_wb", 32'(de_issue), 1);
    tick();
    wb_set(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    de_ir = 16'h7600; de_cs = SR2N;  // ir[13]=1: SR2 taken from ir[11:9] = R3
    #1 chk("s5_cnt_stays_1", 32'(dep_stall), 1);
    tick();
    wb_set(1'b1, 1'b1, 1'b0, 3'd3, 16'h0444);
    #1 chk("s5_wb_cycle", 32'(dep_stall), FWD ? 0 : 1);
    tick();
    wb_set(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1 chk("s5_sr2_free", 32'(dep_stall), 0);
    tick();
    chk("s5_agex_sr2", 32'(agex_sr2), 32'h0444);
    de_ir = mk_add(1, 2, 2); de_cs = DRMUX | LDREG;
    tick();
    chk("dr_mux_r7", 32'(agex_drid), 7);

    // Asynchronous reset while writers are outstanding.
    de_v = 1'b0;
    #1 chk("s6_busy_before", 32'(sb_busy), 1);
    reset = 1'b1;
    model_clear();
    #1 chk("s6_rst_busy", 32'(sb_busy), 0);
    chk("s6_rst_agex_v", 32'(agex_v), 0);
    tick();
    reset = 1'b0;
    de_v = 1'b1; de_ir = mk_add(2, 1, 1); de_cs = SR1N | SR2N | LDREG; de_npc = 16'h3100;
    #1 chk("s6_post_rst_stall", 32'(dep_stall), 0);
    tick();
    chk("s6_post_rst_sr1", 32'(agex_sr1), 0);
    chk("s6_post_rst_v", 32'(agex_v), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
